tx_interface: RTL and testbench
===============================

// Module: tx_interface
// PURPOSE
//  Output stage of the UART calculator: ALU result -> ASCII decimal frame -> uart_tx.
//  Starts when the RX parser flags a complete command (data_ready). Latches the ALU result,
//  converts it to BCD with a sequential double-dabble, and sends one byte per uart_tx handshake.
//  Pulses rd back to the RX parser so it can accept the next command.
// PARAMETERS
//  DBIT       8   ALU result width. Constraint: 10^NDIG > 2^DBIT.
//  NDIG       3   Decimal digits sent. Fixed width; leading zeros are sent.
//  SIGNED_OUT 1   1: result is two's complement, frame starts with '+' or '-'. 0: unsigned, no sign byte.
//  TERM_CHAR  10  Terminator byte (LF).
// PORTS
//  clk          in   1     system clock
//  reset        in   1     asynchronous, active-high
//  data_ready   in   1     level; RX parser has a complete A/B/Op command
//  result       in   DBIT  ALU output; sampled only on frame start
//  tx_done_tick in   1     1-cycle pulse from uart_tx: byte finished
//  tx_start     out  1     1-cycle pulse: uart_tx loads tx_data
//  tx_data      out  8     byte to transmit; stable from tx_start until matching tx_done_tick
//  rd           out  1     1-cycle pulse: frame sent, RX parser may clear its flag
//  busy         out  1     high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; tx_start=0, tx_data=0, rd=0, busy=0; latched result and BCD regs = 0.
//  States: IDLE -> CONV -> SEND_SIGN (only if SIGNED_OUT) -> SEND_DIG -> SEND_TERM -> ACK -> WAIT_LOW -> IDLE.
//  IDLE
//   - On data_ready=1 at edge k: latch result.
//   - Compute magnitude: -result if SIGNED_OUT and MSB=1, else result. Treat it as unsigned DBIT.
//   - Record neg flag. Go to CONV.
//  CONV
//   - Double-dabble, exactly DBIT cycles: add 3 to each BCD nibble >=5, then shift left 1.
//   - First tx_start is asserted in cycle k+DBIT+1.
//  SEND_* states, two phases each:
//   - Phase 1: tx_start=1 for one cycle with tx_data set.
//   - Phase 2: wait for tx_done_tick. tx_start stays 0. A tx_done_tick in the same cycle as tx_start is ignored.
//   - On tx_done_tick: advance to the next byte.
//  SEND_SIGN sends '-' (45) if neg, else '+' (43).
//  SEND_DIG sends NDIG digits, most-significant first, as 48+BCD. Digit counter runs NDIG-1 down to 0.
//  SEND_TERM sends TERM_CHAR.
//  ACK: rd=1 for exactly one cycle, then WAIT_LOW.
//  WAIT_LOW: stay until data_ready=0, then IDLE. A held-high data_ready never causes a second frame.
//  Edge cases:
//   - -2^(DBIT-1) (e.g. 0x80) gives magnitude 128 and is printed correctly.
//   - result may change after latch; it is ignored.
//   - tx_done_tick outside a wait phase is ignored.
//  Reset mid-frame: immediate return to IDLE with reset values. A byte already in flight in uart_tx finishes on its own. No rd is issued.
// STRUCTURE
//  Shared include uart_defs.vh holds:
//   - ASCII constants: ASCII_0=48, ASCII_PLUS=43, ASCII_MINUS=45, ASCII_LF=10.
//   - State encoding localparams for this block.
//  Sub-module bin2bcd_seq (DBIT, NDIG):
//   - inputs start, bin; outputs bcd[4*NDIG-1:0], done.
//   - Iterative double-dabble, DBIT cycles.
//  Top level holds the FSM, byte mux, digit counter and handshake logic.
// TESTING
//  1. SIGNED_OUT=1, result=42, tx_done_tick 20 cycles after each tx_start
//     -> bytes 43,48,52,50,10; one rd pulse after the 5th tick.
//  2. result=8'hFF -> '-','0','0','1',LF.
//     result=8'h80 -> '-','1','2','8',LF.
//  3. SIGNED_OUT=0, result=255 -> '2','5','5',LF (4 tx_start pulses).
//     result=0 -> '0','0','0',LF.
//  4. tx_done_tick held off 1000 cycles -> no repeated tx_start; tx_data stable; busy=1.
//  5. Reset asserted during the 2nd digit -> all outputs 0 next cycle, no rd.
//     New data_ready -> full frame restarts from the sign byte.
//  6. data_ready kept high after rd -> no new tx_start until it drops and rises.
//     Also check first tx_start lands at k+9 for DBIT=8.

Source files
------------

// File: rtl/tx_interface_pkg.sv
// Shared constants, state encoding and helpers for the calculator output stage.
package tx_interface_pkg;

   localparam logic [7:0] ASCII_0     = 8'd48;
   localparam logic [7:0] ASCII_PLUS  = 8'd43;
   localparam logic [7:0] ASCII_MINUS = 8'd45;
   localparam logic [7:0] ASCII_LF    = 8'd10;

   typedef enum logic [2:0] {
      StIdle,
      StConv,
      StSendSign,
      StSendDig,
      StSendTerm,
      StAck,
      StWaitLow
   } tx_state_e;

   function automatic logic [7:0] ascii_digit(input logic [3:0] d);
      return ASCII_0 + {4'd0, d};
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle, DBIT cycles after start.
module bin2bcd_seq
   import tx_interface_pkg::*;
#(
   parameter int unsigned DBIT = 8,
   parameter int unsigned NDIG = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DBIT-1:0]   bin,
   output logic [4*NDIG-1:0] bcd,
   output logic              done
);

   localparam int unsigned CW = $clog2(DBIT + 1);

   logic [DBIT-1:0]   bin_q, bin_d;
   logic [4*NDIG-1:0] bcd_q, bcd_d;
   logic [4*NDIG-1:0] adj;
   logic [CW-1:0]     cnt_q, cnt_d;

   always_comb begin
      adj = bcd_q;
      for (int n = 0; n < int'(NDIG); n++) begin
         if (adj[4*n +: 4] >= 4'd5) begin
            adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      bin_d = bin_q;
      bcd_d = bcd_q;
      cnt_d = cnt_q;
      if (start) begin
         bin_d = bin;
         bcd_d = '0;
         cnt_d = CW'(DBIT);
      end else if (cnt_q != '0) begin
         {bcd_d, bin_d} = {adj[4*NDIG-2:0], bin_q, 1'b0};
         cnt_d          = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         cnt_q <= cnt_d;
      end
   end

   assign bcd  = bcd_q;
   assign done = (cnt_q == '0);

endmodule

// File: rtl/tx_interface.sv
// Calculator output stage: latches the ALU result, converts to decimal and streams
// sign / digits / terminator to uart_tx one handshake at a time.
module tx_interface
   import tx_interface_pkg::*;
#(
   parameter int unsigned DBIT       = 8,
   parameter int unsigned NDIG       = 3,
   parameter bit          SIGNED_OUT = 1'b1,
   parameter logic [7:0]  TERM_CHAR  = ASCII_LF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            data_ready,
   input  logic [DBIT-1:0] result,
   input  logic            tx_done_tick,
   output logic            tx_start,
   output logic [7:0]      tx_data,
   output logic            rd,
   output logic            busy
);

   localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CntW-1:0] LastDig = CntW'(NDIG - 1);

   tx_state_e         state_q, state_d;
   logic              neg_q, neg_d;
   logic [CntW-1:0]   dig_q, dig_d;
   logic              tx_start_q, tx_start_d;
   logic [7:0]        tx_data_q, tx_data_d;

   logic              conv_start;
   logic              conv_done;
   logic [DBIT-1:0]   mag;
   logic [4*NDIG-1:0] bcd;
   logic              tick_ok;

   function automatic logic [3:0] nibble_at(input logic [4*NDIG-1:0] v,
                                            input logic [CntW-1:0]   idx);
      logic [3:0] r;
      r = '0;
      for (int n = 0; n < int'(NDIG); n++) begin
         if (idx == CntW'(n)) r = v[4*n +: 4];
      end
      return r;
   endfunction

   // Most negative input wraps to itself, which read as unsigned is the right magnitude.
   assign mag = (SIGNED_OUT && result[DBIT-1]) ? (~result + DBIT'(1)) : result;

   bin2bcd_seq #(
      .DBIT(DBIT),
      .NDIG(NDIG)
   ) u_bin2bcd (
      .clk  (clk),
      .reset(reset),
      .start(conv_start),
      .bin  (mag),
      .bcd  (bcd),
      .done (conv_done)
   );

   // A tick coinciding with our own start pulse belongs to an earlier byte.
   assign tick_ok = tx_done_tick && !tx_start_q;

   always_comb begin
      state_d    = state_q;
      neg_d      = neg_q;
      dig_d      = dig_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      conv_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (data_ready) begin
               neg_d      = SIGNED_OUT && result[DBIT-1];
               conv_start = 1'b1;
               state_d    = StConv;
            end
         end
         StConv: begin
            if (conv_done) begin
               tx_start_d = 1'b1;
               if (SIGNED_OUT) begin
                  state_d   = StSendSign;
                  tx_data_d = neg_q ? ASCII_MINUS : ASCII_PLUS;
               end else begin
                  state_d   = StSendDig;
                  dig_d     = LastDig;
                  tx_data_d = ascii_digit(nibble_at(bcd, LastDig));
               end
            end
         end
         StSendSign: begin
            if (tick_ok) begin
               state_d    = StSendDig;
               dig_d      = LastDig;
               tx_start_d = 1'b1;
               tx_data_d  = ascii_digit(nibble_at(bcd, LastDig));
            end
         end
         StSendDig: begin
            if (tick_ok) begin
               tx_start_d = 1'b1;
               if (dig_q == '0) begin
                  state_d   = StSendTerm;
                  tx_data_d = TERM_CHAR;
               end else begin
                  dig_d     = dig_q - CntW'(1);
                  tx_data_d = ascii_digit(nibble_at(bcd, dig_q - CntW'(1)));
               end
            end
         end
         StSendTerm: begin
            if (tick_ok) state_d = StAck;
         end
         StAck: begin
            state_d = StWaitLow;
         end
         StWaitLow: begin
            if (!data_ready) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         neg_q      <= 1'b0;
         dig_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         neg_q      <= neg_d;
         dig_q      <= dig_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign rd       = (state_q == StAck);
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_tx_interface.sv
// Bench for tx_interface: signed and unsigned instances, frame model from decimal arithmetic.
module tb_tx_interface;

   localparam int DBIT = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       dr[2];
   logic       tick[2];
   logic       ts[2];
   logic       rdo[2];
   logic       busy[2];
   logic [7:0] res[2];
   logic [7:0] txd[2];

   int         n_cmp = 0;
   int         n_bad = 0;
   int         delay[2];
   int         rd_cnt[2];
   logic [7:0] exp_q[2][$];
   logic [7:0] log_q[2][$];
   logic [7:0] last[2];
   bit         inflight[2];

   always #5 clk = ~clk;

   tx_interface #(.DBIT(8), .NDIG(3), .SIGNED_OUT(1'b1), .TERM_CHAR(8'd10)) u_s (
      .clk(clk), .reset(reset), .data_ready(dr[0]), .result(res[0]),
      .tx_done_tick(tick[0]), .tx_start(ts[0]), .tx_data(txd[0]), .rd(rdo[0]), .busy(busy[0])
   );

   tx_interface #(.DBIT(8), .NDIG(3), .SIGNED_OUT(1'b0), .TERM_CHAR(8'd10)) u_u (
      .clk(clk), .reset(reset), .data_ready(dr[1]), .result(res[1]),
      .tx_done_tick(tick[1]), .tx_start(ts[1]), .tx_data(txd[1]), .rd(rdo[1]), .busy(busy[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Expected frame straight from decimal arithmetic on the input value.
   function automatic void model_push(input int i, input logic [7:0] r);
      bit neg;
      int mag;
      neg = (i == 0) && r[7];
      mag = neg ? 256 - int'(r) : int'(r);
      if (i == 0) exp_q[i].push_back(neg ? 8'd45 : 8'd43);
      exp_q[i].push_back(8'(48 + (mag / 100) % 10));
      exp_q[i].push_back(8'(48 + (mag / 10) % 10));
      exp_q[i].push_back(8'(48 + mag % 10));
      exp_q[i].push_back(8'd10);
   endfunction

   // Stand-in for uart_tx: pulses tx_done_tick delay[i] cycles after each tx_start.
   task automatic responder(input int i);
      int cnt;
      cnt     = 0;
      tick[i] = 1'b0;
      forever begin
         @(negedge clk);
         tick[i] = 1'b0;
         if (reset) cnt = 0;
         else if (ts[i]) cnt = delay[i];
         else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) tick[i] = 1'b1;
         end
      end
   endtask

   task automatic monitor(input int i);
      forever begin
         @(negedge clk);
         if (reset) begin
            inflight[i] = 1'b0;
         end else begin
            if (ts[i]) begin
               if (exp_q[i].size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL spurious_tx_start[%0d]: got data %0d, expected no start", i,
                           txd[i]);
               end else begin
                  chk("tx_data", 32'(txd[i]), 32'(exp_q[i].pop_front()));
               end
               log_q[i].push_back(txd[i]);
               last[i]     = txd[i];
               inflight[i] = 1'b1;
            end else if (inflight[i]) begin
               chk("tx_data_stable", 32'(txd[i]), 32'(last[i]));
            end
            if (rdo[i]) begin
               rd_cnt[i]++;
               chk("rd_after_last_byte", 32'(exp_q[i].size()), 32'd0);
               inflight[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic chk_log(input int i, input int n, input logic [39:0] v);
      chk("frame_len", 32'(log_q[i].size()), 32'(n));
      for (int j = 0; j < n && j < log_q[i].size(); j++) begin
         chk("frame_byte", 32'(log_q[i][j]), 32'(v[8*(n-1-j) +: 8]));
      end
   endtask

   task automatic do_frame(input int i, input logic [7:0] r, input bit drop, input int probe,
                           input logic [7:0] probe_byte);
      int n;
      int c;
      int base;
      bit seen;
      model_push(i, r);
      log_q[i].delete();
      base = rd_cnt[i];
      @(negedge clk);
      dr[i]  = 1'b1;
      res[i] = r;
      n      = 0;
      seen   = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         seen = ts[i];
      end
      chk("first_tx_start_cycle", 32'(n), 32'(DBIT + 2));
      @(negedge clk);
      res[i] = ~r;
      if (probe > 0) begin
         repeat (probe) @(negedge clk);
         chk("hold_busy", 32'(busy[i]), 32'd1);
         chk("hold_single_start", 32'(log_q[i].size()), 32'd1);
         chk("hold_tx_data", 32'(txd[i]), 32'(probe_byte));
      end
      c = 0;
      while (rd_cnt[i] == base && c < 20000) begin
         @(negedge clk);
         c++;
      end
      repeat (3) @(negedge clk);
      chk("rd_pulses", 32'(rd_cnt[i] - base), 32'd1);
      chk("model_drained", 32'(exp_q[i].size()), 32'd0);
      if (drop) dr[i] = 1'b0;
   endtask

   initial responder(0);
   initial responder(1);
   initial monitor(0);
   initial monitor(1);

   initial begin
      int base;
      int c;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         dr[i]       = 1'b0;
         res[i]      = 8'd0;
         delay[i]    = 20;
         rd_cnt[i]   = 0;
         inflight[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("reset_tx_start", 32'(ts[i]), 32'd0);
         chk("reset_tx_data", 32'(txd[i]), 32'd0);
         chk("reset_rd", 32'(rdo[i]), 32'd0);
         chk("reset_busy", 32'(busy[i]), 32'd0);
      end
      reset = 1'b0;

      do_frame(0, 8'd42, 1'b1, 0, 8'd0);
      chk_log(0, 5, {8'd43, 8'd48, 8'd52, 8'd50, 8'd10});
      do_frame(0, 8'hFF, 1'b1, 0, 8'd0);
      chk_log(0, 5, {8'd45, 8'd48, 8'd48, 8'd49, 8'd10});
      do_frame(0, 8'h80, 1'b1, 0, 8'd0);
      chk_log(0, 5, {8'd45, 8'd49, 8'd50, 8'd56, 8'd10});

      do_frame(1, 8'd255, 1'b1, 0, 8'd0);
      chk_log(1, 4, {8'd0, 8'd50, 8'd53, 8'd53, 8'd10});
      do_frame(1, 8'd0, 1'b1, 0, 8'd0);
      chk_log(1, 4, {8'd0, 8'd48, 8'd48, 8'd48, 8'd10});

      // uart_tx stalled: one start, data held, still busy.
      delay[0] = 1000;
      do_frame(0, 8'd7, 1'b1, 990, 8'd43);
      chk_log(0, 5, {8'd43, 8'd48, 8'd48, 8'd55, 8'd10});
      delay[0] = 20;

      // Reset while the second digit is in flight.
      model_push(0, 8'hFB);
      log_q[0].delete();
      base = rd_cnt[0];
      @(negedge clk);
      dr[0]  = 1'b1;
      res[0] = 8'hFB;
      c      = 0;
      while (log_q[0].size() < 3 && c < 500) begin
         @(negedge clk);
         c++;
      end
      chk("second_digit_reached", 32'(log_q[0].size()), 32'd3);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      dr[0] = 1'b0;
      @(posedge clk);
      #1;
      chk("midreset_tx_start", 32'(ts[0]), 32'd0);
      chk("midreset_tx_data", 32'(txd[0]), 32'd0);
      chk("midreset_rd", 32'(rdo[0]), 32'd0);
      chk("midreset_busy", 32'(busy[0]), 32'd0);
      @(negedge clk);
      exp_q[0].delete();
      log_q[0].delete();
      reset = 1'b0;
      repeat (30) @(negedge clk);
      chk("midreset_no_rd", 32'(rd_cnt[0] - base), 32'd0);
      do_frame(0, 8'hFB, 1'b1, 0, 8'd0);
      chk_log(0, 5, {8'd45, 8'd48, 8'd48, 8'd53, 8'd10});

      // data_ready held high after rd must not retrigger.
      do_frame(0, 8'd42, 1'b0, 0, 8'd0);
      repeat (50) @(negedge clk);
      chk("held_dr_no_restart", 32'(log_q[0].size()), 32'd5);
      chk("held_dr_busy", 32'(busy[0]), 32'd1);
      dr[0] = 1'b0;
      @(negedge clk);
      chk("wait_low_released", 32'(busy[0]), 32'd0);
      do_frame(0, 8'd100, 1'b1, 0, 8'd0);
      chk_log(0, 5, {8'd43, 8'd49, 8'd48, 8'd48, 8'd10});

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
